// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: merges per-channel framebuffer write streams into one registered write port
// Ports: clk/reset (async, active-high); ch_we/ch_addr/ch_wdata per-channel pushes;
// ch_full/ch_overflow per-channel status; ovf_clear clears overflow flags;
// mem_write/mem_addr/mem_wdata output word with mem_ready handshake; busy = work pending.
module fb_write_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_full,
  output logic [NUM_CH-1:0]            ch_overflow,
  input  logic                         ovf_clear,
  output logic                         mem_write,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ready,
  output logic                         busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  logic [EW-1:0]     r_mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]     r_wptr [NUM_CH];
  logic [PW-1:0]     r_rptr [NUM_CH];
  logic [CW-1:0]     r_cnt [NUM_CH];
  logic [GW-1:0]     r_last;
  logic [GW-1:0]     w_sel;
  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic              w_load;
  logic              w_grant;
  logic [EW-1:0]     w_head;
  // k-th candidate in search order: fixed priority walks 0..NUM_CH-1,
  // round-robin walks last+1 .. last+NUM_CH modulo NUM_CH
  function automatic logic [GW-1:0] cand(input logic [GW-1:0] last, input int k);
    return GW'(ARB_MODE != 0 ? k - 1 : (int'(last) + k) % NUM_CH);
  endfunction
  always_comb begin
    w_nonempty = '0;
    ch_full    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_nonempty[i] = r_cnt[i] != '0;
      ch_full[i]    = r_cnt[i] == CW'(FIFO_DEPTH);
    end
  end
  // scan from lowest to highest priority so the earliest candidate overwrites last
  always_comb begin
    w_sel = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (w_nonempty[cand(r_last, k)]) w_sel = cand(r_last, k);
  end
  assign w_push  = ch_we & ~ch_full;
  assign w_load  = ~mem_write | mem_ready;
  assign w_grant = w_load & |w_nonempty;
  assign w_pop   = w_grant ? NUM_CH'(1) << w_sel : '0;
  assign w_head  = r_mem[w_sel][r_rptr[w_sel]];
  assign busy    = |w_nonempty | mem_write;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (w_push[i]) r_mem[i][r_wptr[i]] <= {ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH], ch_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      ch_overflow <= '0;
      r_last      <= GW'(NUM_CH - 1);
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      // a fresh drop in the same cycle as a clear keeps its flag set
      ch_overflow <= (ovf_clear ? '0 : ch_overflow) | (ch_we & ch_full);
      if (w_grant) r_last <= w_sel;
      if (w_load) mem_write <= |w_nonempty;
      if (w_grant) {mem_addr, mem_wdata} <= w_head;
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_fb_write_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ch_we = '0;
  logic [31:0] ch_addr = '0;
  logic [63:0] ch_wdata = '0;
  logic        ovf_clear = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  rr_full, rr_ovf, fp_full, fp_ovf;
  logic        rr_wr, rr_busy, fp_wr, fp_busy;
  logic [15:0] rr_addr, fp_addr;
  logic [31:0] rr_data, fp_data;
  logic [47:0] q_rr[$];
  logic [47:0] q_fp[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr_rr = 0;
  int          n_wr_fp = 0;
  int          b_rr, b_fp;
  logic        hold_rr = 1'b0;
  logic        hold_fp = 1'b0;
  logic [47:0] pw_rr, pw_fp;
  always #5 clk = ~clk;
  fb_write_arbiter #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_full(rr_full), .ch_overflow(rr_ovf), .ovf_clear(ovf_clear), .mem_write(rr_wr),
    .mem_addr(rr_addr), .mem_wdata(rr_data), .mem_ready(mem_ready), .busy(rr_busy));
  fb_write_arbiter #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_full(fp_full), .ch_overflow(fp_ovf), .ovf_clear(ovf_clear), .mem_write(fp_wr),
    .mem_addr(fp_addr), .mem_wdata(fp_data), .mem_ready(mem_ready), .busy(fp_busy));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mon(input int d, input logic w, input logic [47:0] word);
    logic [47:0] e;
    if (d == 0 ? hold_rr : hold_fp) chk(d == 0 ? "rr_hold" : "fp_hold", {w, word}, {1'b1, d == 0 ? pw_rr : pw_fp});
    if (w && mem_ready) begin
      if (d == 0) begin
        n_wr_rr++;
        if (q_rr.size() == 0) chk("rr_spurious_wr", 64'(w), 64'd0);
        else begin
          e = q_rr.pop_front();
          chk("rr_word", word, e);
        end
      end else begin
        n_wr_fp++;
        if (q_fp.size() == 0) chk("fp_spurious_wr", 64'(w), 64'd0);
        else begin
          e = q_fp.pop_front();
          chk("fp_word", word, e);
        end
      end
    end
    if (d == 0) begin
      hold_rr = w & ~mem_ready;
      pw_rr   = word;
    end else begin
      hold_fp = w & ~mem_ready;
      pw_fp   = word;
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      hold_rr = 1'b0;
      hold_fp = 1'b0;
    end else begin
      mon(0, rr_wr, {rr_addr, rr_data});
      mon(1, fp_wr, {fp_addr, fp_data});
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int c, input logic [15:0] a, input logic [31:0] d);
    ch_we[c] = 1'b1;
    ch_addr[c*16 +: 16] = a;
    ch_wdata[c*32 +: 32] = d;
  endtask
  task automatic expect_both(input logic [47:0] w);
    q_rr.push_back(w);
    q_fp.push_back(w);
  endtask
  initial begin
    #2;
    chk("rst_wr", {rr_wr, fp_wr}, 0);
    chk("rst_addr", {rr_addr, fp_addr}, 0);
    chk("rst_data", {rr_data, fp_data}, 0);
    chk("rst_busy", {rr_busy, fp_busy}, 0);
    chk("rst_full", {rr_full, fp_full}, 0);
    chk("rst_ovf", {rr_ovf, fp_ovf}, 0);
    repeat (2) step;
    reset = 1'b0;
    step;
    // single word latency
    put(0, 16'h0010, 32'hDEADBEEF);
    expect_both({16'h0010, 32'hDEADBEEF});
    step;
    ch_we = '0;
    chk("t1_not_yet", rr_wr, 0);
    step;
    chk("t1_wr", rr_wr, 1);
    chk("t1_word", {rr_addr, rr_data}, {16'h0010, 32'hDEADBEEF});
    chk("t1_busy", rr_busy, 1);
    step;
    chk("t1_wr_done", rr_wr, 0);
    chk("t1_busy_done", rr_busy, 0);
    // fairness vs priority with both channels streaming
    reset = 1'b1;
    step;
    reset = 1'b0;
    step;
    for (int k = 0; k < 4; k++) begin
      q_rr.push_back({16'h0100 + 16'(k), 32'hA0000000 + 32'(k)});
      q_rr.push_back({16'h0200 + 16'(k), 32'hB0000000 + 32'(k)});
      q_fp.push_back({16'h0100 + 16'(k), 32'hA0000000 + 32'(k)});
    end
    for (int k = 0; k < 4; k++) q_fp.push_back({16'h0200 + 16'(k), 32'hB0000000 + 32'(k)});
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        put(0, 16'h0100 + 16'(k), 32'hA0000000 + 32'(k));
        put(1, 16'h0200 + 16'(k), 32'hB0000000 + 32'(k));
      end else ch_we = '0;
      step;
      if (k >= 1 && k <= 8) chk("arb_stream", {rr_wr, fp_wr}, 2'b11);
      if (k == 9) chk("arb_drained", {rr_wr, fp_wr}, 2'b00);
      if (k == 3) chk("arb_full", {rr_full, fp_full}, 4'b0010);
    end
    chk("arb_q_rr", q_rr.size(), 0);
    chk("arb_q_fp", q_fp.size(), 0);
    // backpressure, full, overflow
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      put(0, 16'h0300 + 16'(k), 32'hC0000000 + 32'(k));
      if (k < 5) expect_both({16'h0300 + 16'(k), 32'hC0000000 + 32'(k)});
      step;
      if (k == 3) chk("bp_not_full", {rr_full, fp_full}, 4'b0000);
      if (k == 4) chk("bp_full", {rr_full, fp_full, rr_ovf, fp_ovf}, 8'b0101_0000);
      if (k == 5) chk("bp_ovf", {rr_ovf, fp_ovf}, 4'b0101);
    end
    ovf_clear = 1'b1;
    step;
    chk("bp_ovf_wins", {rr_ovf, fp_ovf}, 4'b0101);
    ch_we = '0;
    step;
    ovf_clear = 1'b0;
    chk("bp_ovf_clr", {rr_ovf, fp_ovf}, 4'b0000);
    chk("bp_stage", {rr_wr, rr_addr}, {1'b1, 16'h0300});
    b_rr = n_wr_rr;
    b_fp = n_wr_fp;
    mem_ready = 1'b1;
    repeat (8) step;
    chk("bp_count_rr", n_wr_rr - b_rr, 5);
    chk("bp_count_fp", n_wr_fp - b_fp, 5);
    chk("bp_unfull", {rr_full, fp_full}, 4'b0000);
    // toggling ready
    b_rr = n_wr_rr;
    for (int k = 0; k < 14; k++) begin
      mem_ready = (k % 2) == 1;
      if (k < 4) begin
        put(1, 16'h0400 + 16'(k), 32'hD0000000 + 32'(k));
        expect_both({16'h0400 + 16'(k), 32'hD0000000 + 32'(k)});
      end else ch_we = '0;
      step;
    end
    mem_ready = 1'b1;
    step;
    chk("stall_count", n_wr_rr - b_rr, 4);
    chk("stall_q", q_rr.size() + q_fp.size(), 0);
    // reset with words in flight
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(0, 16'h0500 + 16'(k), 32'hE0000000 + 32'(k));
      step;
    end
    ch_we = '0;
    chk("mid_busy_pre", {rr_wr, rr_busy}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_wr", {rr_wr, fp_wr}, 0);
    chk("mid_word", {rr_addr, rr_data}, 0);
    chk("mid_busy", {rr_busy, fp_busy}, 0);
    q_rr.delete();
    q_fp.delete();
    step;
    reset = 1'b0;
    mem_ready = 1'b1;
    b_rr = n_wr_rr;
    b_fp = n_wr_fp;
    repeat (4) step;
    chk("mid_no_wr", (n_wr_rr - b_rr) + (n_wr_fp - b_fp), 0);
    put(0, 16'h0600, 32'hF0000000);
    put(1, 16'h0700, 32'hF1000000);
    expect_both({16'h0600, 32'hF0000000});
    expect_both({16'h0700, 32'hF1000000});
    step;
    ch_we = '0;
    repeat (4) step;
    chk("end_q_rr", q_rr.size(), 0);
    chk("end_q_fp", q_fp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
